nios_audio_i2s_tx: RTL and testbench
====================================

NIOS_AUDIO_I2S_TX -- requirements
Module: nios_audio_i2s_tx

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024: consecutive cycles of pll_locked=1 required before output starts.
REQ-002 SHALL have parameter SAMPLE_W, default 16: bits per channel sample.
REQ-003 clk  in  1  audio master clock, 18.432 MHz; the audio PLL outclk_0 drives it.
REQ-004 reset_n  in  1  reset, asynchronous assert, active-low; clk is the only clock.
REQ-005 pll_locked  in  1  audio PLL locked indication, already synchronous to clk.
REQ-006 enable  in  1  software run request.
REQ-007 rate_sel  in  2  sample rate: 0=48 kHz (div 6), 1=32 kHz (div 9), 2=8 kHz (div 36), 3=treated as 0.
REQ-008 s_valid  in  1  sample pair valid.
REQ-009 s_left / s_right  in  SAMPLE_W each  two's-complement channel samples.
REQ-010 s_ready  out  1  sample pair accepted when s_valid and s_ready are both 1.
REQ-011 bclk / lrclk / sdata  out  1 each  I2S bit clock, word select (0=left), serial data.
REQ-012 running  out  1  high in RUN or DRAIN.
REQ-013 underrun  out  1  one-cycle pulse when a frame starts without a held sample.

Function
REQ-014 SHALL implement states IDLE, QUAL, RUN, DRAIN.
REQ-015 IDLE->QUAL when enable=1 and pll_locked=1; in QUAL, qual counter increments each cycle with pll_locked=1.
REQ-016 QUAL->RUN when the counter reaches LOCK_CYCLES-1; QUAL->IDLE if enable=0.
REQ-017 pll_locked=0 in any state -> IDLE on the next edge; clears the counter, dividers and holding register; does not pulse underrun.
REQ-018 RUN->DRAIN when enable=0; DRAIN->IDLE at the bclk fall that ends bit 63; enable=1 during DRAIN has no effect.
REQ-019 rate_sel is latched as div on entry to RUN; later changes are ignored until the next entry.
REQ-020 Divider cnt counts 0..div-1 and wraps; bclk=0 while cnt < div-div/2 (integer division), else 1; div 9 gives 5 cycles low and 4 cycles high.
REQ-021 Each cnt wrap to 0 is a bclk fall; bit_cnt (0..63) advances on each bclk fall and wraps 63->0.
REQ-022 lrclk=0 for bit_cnt 0..31 and 1 for 32..63; lrclk and sdata change only at a bclk fall.
REQ-023 sdata carries left MSB-first on bit_cnt 1..SAMPLE_W and right MSB-first on bit_cnt 33..32+SAMPLE_W; all other bit positions are 0.
REQ-024 Frame start occurs on the first RUN cycle (cnt=0, bit_cnt=0) and at each 63->0 wrap.
REQ-025 Frame start loads the holding register into the frame shift register and empties the holding register.
REQ-026 If the holding register is empty at frame start, zeros are loaded and underrun pulses in that cycle.
REQ-027 s_ready = (state==RUN) and holding register empty; a handshake fills the holding register on the next edge.
REQ-028 Handshake in the same cycle as a frame start with an empty holding register: zeros are loaded, underrun pulses, and the accepted pair is held for the next frame.
REQ-029 No frame start occurs in DRAIN; the frame in progress completes, and a held pair is discarded on entry to IDLE.
REQ-030 In IDLE and QUAL: bclk=lrclk=sdata=0, running=0, s_ready=0.

Reset
REQ-031 reset_n=0 SHALL immediately force state=IDLE, all counters 0, holding register empty, and every output 0.
REQ-032 After release, the block SHALL leave IDLE only on the first clk edge that meets REQ-015.

Verification
REQ-033 reset_n released, enable=1, pll_locked=1, LOCK_CYCLES=1024 -> running rises 1024 cycles after entry to QUAL; bclk period 6 cycles; lrclk period 384 cycles.
REQ-034 rate_sel=1, pair L=16'h8001 R=16'h7FFE supplied before the first frame -> bclk 5 low/4 high; sdata bits 1..16 = 1000000000000001, bits 33..48 = 0111111111111110.
REQ-035 No s_valid for 3 frames -> 3 underrun pulses, one per frame start; sdata stays 0.
REQ-036 pll_locked=0 at bit_cnt=20 -> IDLE next cycle; bclk/lrclk/sdata=0; no underrun; requalification of 1024 cycles required.
REQ-037 enable=0 at bit_cnt=10 -> running stays 1 until the bit-63 bclk fall, then 0; s_ready=0 throughout DRAIN.
REQ-038 s_valid held high -> exactly one handshake per frame; the handshake that coincides with the frame start where the holding register is empty gives one underrun, and that pair appears in the following frame.

Source files
------------

// File: rtl/nios_audio_i2s_tx.sv
// I2S transmitter for the audio codec path.
// Waits for the audio PLL to stay locked for LOCK_CYCLES cycles, then produces
// bclk/lrclk/sdata in 64-bit-per-frame I2S format from sample pairs handed over
// on a valid/ready port. A single holding register decouples software from the
// frame timing; an empty holding register at frame start sends silence and
// raises underrun for one cycle.
//
// state | meaning
// IDLE  | outputs quiet, waiting for enable with the PLL locked
// QUAL  | counting consecutive locked cycles before trusting the clock
// RUN   | transmitting frames, accepting sample pairs
// DRAIN | finishing the current frame, no new frame starts, no new pairs
module nios_audio_i2s_tx #(
  parameter int LOCK_CYCLES = 1024,
  parameter int SAMPLE_W    = 16
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                pll_locked_i,
  input  logic                enable_i,
  input  logic [1:0]          rate_sel_i,
  input  logic                s_valid_i,
  input  logic [SAMPLE_W-1:0] s_left_i,
  input  logic [SAMPLE_W-1:0] s_right_i,
  output logic                s_ready_o,
  output logic                bclk_o,
  output logic                lrclk_o,
  output logic                sdata_o,
  output logic                running_o,
  output logic                underrun_o
);

  localparam int QW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_QUAL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [QW-1:0]         qual_q;
  logic [5:0]            div_q, div_sel;
  logic [5:0]            cnt_q;
  logic [5:0]            bit_cnt_q;
  logic                  hold_full_q;
  logic [2*SAMPLE_W-1:0] hold_q;
  logic [2*SAMPLE_W-1:0] frame_q;
  logic                  active, keep_cnt, cnt_wrap, last_bit, qual_done;
  logic                  frame_start, handshake, in_window;

  assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign keep_cnt    = active && ((state_d == ST_RUN) || (state_d == ST_DRAIN));
  assign cnt_wrap    = active && (cnt_q == div_q - 6'd1);
  assign last_bit    = (bit_cnt_q == 6'd63);
  assign qual_done   = (qual_q == QW'(LOCK_CYCLES - 1));
  // A frame never starts in the cycle the PLL drops, so no underrun is flagged then.
  assign frame_start = (state_q == ST_RUN) && (cnt_q == 6'd0) && (bit_cnt_q == 6'd0)
                       && pll_locked_i;
  assign s_ready_o   = (state_q == ST_RUN) && !hold_full_q;
  assign handshake   = s_valid_i && s_ready_o;
  assign underrun_o  = frame_start && !hold_full_q;
  // Data slots occupy positions 1..SAMPLE_W of each 32-bit half frame.
  assign in_window   = (bit_cnt_q[4:0] != 5'd0) && (int'(bit_cnt_q[4:0]) <= SAMPLE_W);
  assign bclk_o      = active && (cnt_q >= div_q - (div_q >> 1));
  assign lrclk_o     = active && bit_cnt_q[5];
  assign sdata_o     = active && in_window && frame_q[2*SAMPLE_W-1];
  assign running_o   = active;

  // Decode the requested sample rate into the bclk divider.
  always_comb begin
    case (rate_sel_i)
      2'd1:    div_sel = 6'd9;
      2'd2:    div_sel = 6'd36;
      default: div_sel = 6'd6;
    endcase
  end

  // Next-state logic; losing PLL lock overrides everything.
  always_comb begin
    state_d = state_q;
    if (!pll_locked_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (enable_i) state_d = ST_QUAL;
        ST_QUAL: begin
          if (!enable_i)      state_d = ST_IDLE;
          else if (qual_done) state_d = ST_RUN;
        end
        ST_RUN:   if (!enable_i) state_d = ST_DRAIN;
        ST_DRAIN: if (cnt_wrap && last_bit) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State, lock qualification counter and latched divider.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      qual_q  <= '0;
      div_q   <= 6'd6;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_QUAL) && (state_d == ST_QUAL)) qual_q <= qual_q + QW'(1);
      else                                             qual_q <= '0;
      if ((state_q == ST_QUAL) && (state_d == ST_RUN)) div_q <= div_sel;
    end
  end

  // bclk divider and bit position within the 64-bit frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else if (!keep_cnt) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else if (cnt_wrap) begin
      cnt_q     <= '0;
      bit_cnt_q <= bit_cnt_q + 6'd1;
    end else begin
      cnt_q     <= cnt_q + 6'd1;
    end
  end

  // Holding register and frame shift register; a pair accepted on a frame
  // start with an empty holding register waits for the following frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      frame_q     <= '0;
    end else if (state_d == ST_IDLE) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      frame_q     <= '0;
    end else begin
      if (frame_start) begin
        frame_q     <= hold_full_q ? hold_q : '0;
        hold_full_q <= handshake;
      end else begin
        if (handshake) hold_full_q <= 1'b1;
        if (cnt_wrap && in_window) frame_q <= {frame_q[2*SAMPLE_W-2:0], 1'b0};
      end
      if (handshake) hold_q <= {s_left_i, s_right_i};
    end
  end

endmodule

// File: tb/tb_nios_audio_i2s_tx.sv
// Testbench for nios_audio_i2s_tx: a time-based reference model checks every
// output every cycle, plus a rate table and directed corner-case sequences.
`timescale 1ns/1ps
module tb_nios_audio_i2s_tx;
  localparam int LOCK = 1024;
  localparam int SW   = 16;

  logic          clk = 1'b0, rst_n = 1'b0, pll = 1'b0, en = 1'b0, sv = 1'b0;
  logic [1:0]    rate = 2'd0;
  logic [SW-1:0] sl = '0, sr = '0;
  logic          s_ready, bclk, lrclk, sdata, running, underrun;

  int checks = 0;
  int errors = 0;

  nios_audio_i2s_tx #(.LOCK_CYCLES(LOCK), .SAMPLE_W(SW)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .pll_locked_i(pll), .enable_i(en),
    .rate_sel_i(rate), .s_valid_i(sv), .s_left_i(sl), .s_right_i(sr),
    .s_ready_o(s_ready), .bclk_o(bclk), .lrclk_o(lrclk), .sdata_o(sdata),
    .running_o(running), .underrun_o(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name, input int lim);
    checks++;
    errors++;
    $display("FAIL timeout %s: no event within %0d cycles at %0t", name, lim, $time);
  endtask

  function automatic logic [5:0] pack();
    return {running, s_ready, underrun, bclk, lrclk, sdata};
  endfunction

  // Reference model: output waveforms computed from elapsed time since RUN entry.
  int m_mode = 0, m_qn = 0, m_t = 0, m_div = 6, bp, ph, b5;
  bit m_held = 0, act_m, fs, er, hs, eu, eb, el, es;
  logic [2*SW-1:0] m_hold = '0, m_cur = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_qn = 0; m_t = 0; m_div = 6; m_held = 0; m_hold = '0; m_cur = '0;
      check("reset_outputs", pack(), 0);
    end else begin
      bp = (m_t / m_div) % 64;
      ph = m_t % m_div;
      b5 = bp % 32;
      act_m = (m_mode >= 2);
      if (m_mode == 3 && (m_t % (64 * m_div)) == 0) m_cur = '0;
      fs = (m_mode == 2) && ((m_t % (64 * m_div)) == 0) && pll;
      er = (m_mode == 2) && !m_held;
      hs = sv && er;
      eu = fs && !m_held;
      eb = act_m && (ph >= m_div - m_div / 2);
      el = act_m && (bp >= 32);
      es = 0;
      if (act_m && b5 >= 1 && b5 <= SW) es = (bp < 32) ? m_cur[2*SW-b5] : m_cur[SW-b5];
      check("cycle", pack(), {act_m, er, eu, eb, el, es});
      if (!pll) begin
        m_mode = 0; m_held = 0; m_cur = '0;
      end else begin
        case (m_mode)
          0: if (en) begin m_mode = 1; m_qn = 0; end
          1: begin
            if (!en) m_mode = 0;
            else if (m_qn == LOCK - 1) begin
              m_mode = 2; m_t = 0;
              m_div = (rate == 2'd1) ? 9 : (rate == 2'd2) ? 36 : 6;
            end else m_qn++;
          end
          2: begin
            if (fs) begin
              m_cur = m_held ? m_hold : '0;
              m_held = hs;
            end else if (hs) m_held = 1;
            if (hs) m_hold = {sl, sr};
            if (!en) m_mode = 3;
            m_t++;
          end
          default: begin
            if (bp == 63 && ph == m_div - 1) begin
              m_mode = 0; m_held = 0; m_cur = '0;
            end else m_t++;
          end
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit sig(input int s);
    case (s)
      0:       return bclk;
      1:       return lrclk;
      default: return running;
    endcase
  endfunction

  task automatic wait_level(input int s, input bit v, input int lim, output int n);
    n = 0;
    while (sig(s) != v && n < lim) begin tick(1); n++; end
    if (sig(s) != v) timeout($sformatf("sig%0d", s), lim);
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; pll = 0; sv = 0;
    tick(2);
    rst_n = 1;
    tick(1);
  endtask

  task automatic start_run(input logic [1:0] r, output int lat);
    rate = r; en = 1; pll = 1;
    tick(1);
    lat = 0;
    while (!running && lat < LOCK + 100) begin tick(1); lat++; end
    if (!running) timeout("start_run", LOCK + 100);
  endtask

  task automatic capture_frame(output logic [63:0] f);
    int n;
    f = '0;
    wait_level(1, 1, 5000, n);
    wait_level(1, 0, 5000, n);
    for (int i = 0; i < 64; i++) begin
      wait_level(0, 1, 100, n);
      f[i] = sdata;
      wait_level(0, 0, 100, n);
    end
  endtask

  typedef struct {
    logic [1:0] rate;
    int         lo;
    int         hi;
    int         lrp;
  } vec_t;

  initial begin
    vec_t          tbl[4];
    int            lat, lo, hi, n1, n2, cnt_u, cnt_s, cnt_h, rdy, dens;
    logic [63:0]   f, pad;
    logic [SW-1:0] lw, rw;

    tbl[0] = '{2'd0, 3, 3, 384};
    tbl[1] = '{2'd1, 5, 4, 576};
    tbl[2] = '{2'd2, 18, 18, 2304};
    tbl[3] = '{2'd3, 3, 3, 384};

    rst_n = 0; en = 1; pll = 1; sv = 1;
    tick(3);
    check("reset_hold_outputs", pack(), 0);

    // rate table: qualification latency, bclk duty and lrclk period
    foreach (tbl[i]) begin
      do_reset();
      start_run(tbl[i].rate, lat);
      check("qual_latency", lat, LOCK);
      wait_level(0, 1, 100, n1);
      wait_level(0, 0, 100, n1);
      lo = 0; while (!bclk && lo < 100) begin tick(1); lo++; end
      hi = 0; while (bclk && hi < 100) begin tick(1); hi++; end
      check("bclk_low", lo, tbl[i].lo);
      check("bclk_high", hi, tbl[i].hi);
      wait_level(1, 0, 5000, n1);
      wait_level(1, 1, 5000, n1);
      wait_level(1, 0, 5000, n1);
      wait_level(1, 1, 5000, n2);
      check("lrclk_period", n1 + n2, tbl[i].lrp);
    end

    // known pair at rate 1 appears in the frame after the first
    do_reset();
    sl = 16'h8001; sr = 16'h7FFE; sv = 1;
    start_run(2'd1, lat);
    capture_frame(f);
    pad = f;
    for (int j = 0; j < SW; j++) begin
      lw[SW-1-j] = f[1+j];
      rw[SW-1-j] = f[33+j];
      pad[1+j] = 1'b0;
      pad[33+j] = 1'b0;
    end
    check("left_word", lw, 16'h8001);
    check("right_word", rw, 16'h7FFE);
    check("pad_bits", pad, 0);

    // three frames with no samples
    do_reset();
    sv = 0;
    start_run(2'd0, lat);
    cnt_u = 0; cnt_s = 0;
    for (int i = 0; i < 3 * 384; i++) begin
      if (underrun) cnt_u++;
      if (sdata) cnt_s++;
      tick(1);
    end
    check("underrun_count", cnt_u, 3);
    check("silent_sdata", cnt_s, 0);

    // PLL drop at bit 20 then requalification
    tick(20 * 6 + 1);
    pll = 0;
    check("drop_underrun", underrun, 0);
    tick(1);
    check("drop_outputs", pack(), 0);
    start_run(2'd0, lat);
    check("requal_latency", lat, LOCK);

    // disable at bit 10 -> drain to end of frame
    tick(10 * 6 + 1);
    en = 0;
    n1 = 0; rdy = 0;
    while (running && n1 < 1000) begin
      tick(1); n1++;
      if (running && s_ready) rdy++;
    end
    check("drain_length", n1, 323);
    check("drain_ready", rdy, 0);

    // s_valid held: one handshake per frame, one underrun
    sv = 1; sl = 16'h1234; sr = 16'hABCD;
    start_run(2'd0, lat);
    cnt_h = 0; cnt_u = 0;
    for (int i = 0; i < 4 * 384; i++) begin
      if (sv && s_ready) begin cnt_h++; sl = sl + 16'd3; sr = sr - 16'd5; end
      if (underrun) cnt_u++;
      tick(1);
    end
    check("held_handshakes", cnt_h, 4);
    check("held_underruns", cnt_u, 1);

    // randomized traffic against the reference model
    for (int s = 0; s < 6; s++) begin
      do_reset();
      start_run(2'($urandom_range(0, 3)), lat);
      check("rand_qual", lat, LOCK);
      dens = $urandom_range(1, 4);
      for (int c = 0; c < 2500; c++) begin
        sv = ($urandom_range(0, 4) < dens);
        sl = SW'($urandom); sr = SW'($urandom);
        if ($urandom_range(0, 199) == 0) rate = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 999) == 0) en = ~en;
        if ($urandom_range(0, 1999) == 0) pll = 0;
        else if (!pll && $urandom_range(0, 9) == 0) pll = 1;
        tick(1);
      end
    end

    // asynchronous reset while running
    do_reset();
    start_run(2'd0, lat);
    tick(100);
    rst_n = 0;
    #2;
    check("async_reset", pack(), 0);
    tick(1);
    rst_n = 1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
